// File: rtl/instr_fetch_queue.sv
`default_nettype none
//============================================================================
// Module   : instr_fetch_queue
// Brief    : Instruction-fetch FSM with a DEPTH-entry prefetch queue and
//            redirect/discard handling. Optional perf counters: IFQ_PERF_EN.
// Revision : 1.0 - initial release
//============================================================================
module instr_fetch_queue #(
    parameter int AW                = 32,
    parameter int W                 = 32,
    parameter int DEPTH             = 4,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_adr,
    input  logic [W-1:0]  imem_rdata,
    input  logic          imem_ack,
    input  logic          imem_abort,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_instr,
    output logic [AW-1:0] out_pc4
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0]   fetch_cnt,
    output logic [31:0]   discard_cnt
`endif
);

    localparam int c_IDX_W = $clog2(DEPTH);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;

    localparam logic [c_IDX_W:0] c_PTR_ONE = {{c_IDX_W{1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [AW-1:0]    r_fpc;
    logic [AW-1:0]    r_adr;
    logic             r_discard;
    logic [c_IDX_W:0] r_wptr;
    logic [c_IDX_W:0] r_rptr;
    logic [W-1:0]     r_instr_mem [DEPTH];
    logic [AW-1:0]    r_pc4_mem   [DEPTH];

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_in_wait;
    logic             w_resp;
    logic             w_ack_ok;
    logic             w_drop;
    logic             w_push;
    logic [AW-1:0]    w_fpc_inc;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[c_IDX_W] != r_rptr[c_IDX_W]) &&
                       (r_wptr[c_IDX_W-1:0] == r_rptr[c_IDX_W-1:0]);
    assign w_pop     = !w_empty && out_ready;
    assign w_in_wait = (r_state == c_WAIT);
    assign w_resp    = w_in_wait && (imem_ack || imem_abort);
    // abort has precedence over ack when both arrive together
    assign w_ack_ok  = w_in_wait && imem_ack && !imem_abort;
    assign w_drop    = r_discard || redirect;
    assign w_push    = w_ack_ok && !w_drop;
    assign w_fpc_inc = r_fpc + AW'(4);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                // slot reserved at issue, so a pop this cycle frees room
                if (!redirect && (!w_full || w_pop)) begin
                    w_state_nxt = c_REQ;
                end
            end
            c_REQ: begin
                w_state_nxt = c_WAIT;
            end
            c_WAIT: begin
                if (imem_abort) begin
                    w_state_nxt = w_drop ? c_IDLE : c_REQ;
                end else if (imem_ack) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= c_IDLE;
            r_fpc     <= RESET_PC;
            r_adr     <= RESET_PC;
            r_discard <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (redirect) begin
                r_fpc <= redirect_pc;
            end else if (w_push) begin
                r_fpc <= w_fpc_inc;
            end

            // address for the memory is frozen once the fetch leaves IDLE
            if (r_state == c_IDLE) begin
                r_adr <= r_fpc;
            end

            if (w_resp) begin
                r_discard <= 1'b0;
            end else if (redirect && (r_state != c_IDLE)) begin
                r_discard <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr_mem[i] <= '0;
                r_pc4_mem[i]   <= '0;
            end
        end else begin
            if (w_push) begin
                r_instr_mem[r_wptr[c_IDX_W-1:0]] <= imem_rdata;
                r_pc4_mem[r_wptr[c_IDX_W-1:0]]   <= w_fpc_inc;
                r_wptr <= r_wptr + c_PTR_ONE;
            end

            if (redirect) begin
                r_rptr <= r_wptr;
            end else if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
        end
    end

    assign imem_req  = (r_state == c_REQ);
    assign imem_adr  = (r_state == c_IDLE) ? r_fpc : r_adr;
    assign out_valid = !w_empty;
    assign out_instr = r_instr_mem[r_rptr[c_IDX_W-1:0]];
    assign out_pc4   = r_pc4_mem[r_rptr[c_IDX_W-1:0]];

`ifdef IFQ_PERF_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_discard_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fetch_cnt   <= '0;
            r_discard_cnt <= '0;
        end else begin
            if (w_push) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_resp && w_drop) begin
                r_discard_cnt <= r_discard_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt   = r_fetch_cnt;
    assign discard_cnt = r_discard_cnt;
`endif

endmodule
`default_nettype wire
